// File: rtl/apb_master_pkg.sv
// APB master shared types: FSM states, command opcodes,
// and the ECC block register map.
package apb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_DONE,
    ST_ERR
  } apb_state_e;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_WAIT    = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_e;

  localparam logic [7:0] REG_CTRL           = 8'h00;
  localparam logic [7:0] REG_DATA_IN        = 8'h04;
  localparam logic [7:0] REG_CODEWORD_WIDTH = 8'h08;
  localparam logic [7:0] REG_NOISE          = 8'h0C;

  function automatic logic is_apb_op(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/apb_master.sv
// Command-driven APB master for the ECC block: single
// zero-wait-state transfers plus a bounded wait on done.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_error,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  apb_state_e    r_state;
  apb_state_e    w_next;
  cmd_op_e       r_op;
  cmd_op_e       w_op;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          w_accept;
  logic          w_rsp_valid;
  logic          w_rsp_error;
  logic          w_cap;
  logic          w_psel;
  logic          w_penable;
  logic          w_pwrite;

  assign w_accept = cmd_valid & cmd_ready;

  // Next state, counter and next registered outputs.
  always_comb begin
    w_next      = r_state;
    w_cnt       = r_cnt;
    w_rsp_valid = 1'b0;
    w_rsp_error = 1'b0;
    w_cap       = 1'b0;
    w_op        = (r_state == ST_IDLE) ?
                  cmd_op_e'(cmd_op) : r_op;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (cmd_op_e'(cmd_op))
            OP_WRITE,
            OP_READ: w_next = ST_SETUP;
            OP_WAIT: begin
              w_next = ST_WAIT_DONE;
              w_cnt  = '0;
            end
            default: w_next = ST_ERR;
          endcase
        end
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        w_next      = ST_IDLE;
        w_rsp_valid = 1'b1;
        w_cap       = (r_op == OP_READ);
      end
      ST_WAIT_DONE: begin
        if (operation_done) begin
          w_next      = ST_IDLE;
          w_rsp_valid = 1'b1;
        end else if (r_cnt == CNT_MAX) begin
          w_next      = ST_IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_error = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_ERR: begin
        w_next      = ST_IDLE;
        w_rsp_valid = 1'b1;
        w_rsp_error = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    w_psel    = (w_next == ST_SETUP) ||
                (w_next == ST_ACCESS);
    w_penable = (w_next == ST_ACCESS);
    w_pwrite  = w_psel && (w_op == OP_WRITE);
  end

  // State, counter and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_WRITE;
      r_cnt     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      cmd_ready <= (w_next == ST_IDLE);
      rsp_valid <= w_rsp_valid;
      rsp_error <= w_rsp_error;
      PSEL      <= w_psel;
      PENABLE   <= w_penable;
      PWRITE    <= w_pwrite;
      if (w_accept) begin
        r_op <= cmd_op_e'(cmd_op);
      end
      if (w_accept && is_apb_op(cmd_op)) begin
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (w_cap) begin
        rsp_rdata <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: scoreboard of
// responses plus cycle-exact APB phase checks.
module tb_apb_master;
  import apb_master_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PRDATA = '0;
  logic          operation_done = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t sb_q[$];
  logic [DW-1:0] m_rdata = '0;

  apb_master #(
    .AMBA_ADDR_WIDTH(AW),
    .AMBA_WORD(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PRDATA(PRDATA),
    .operation_done(operation_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic e);
    rsp_t r;
    r.err   = e;
    r.rdata = m_rdata;
    sb_q.push_back(r);
  endtask

  // Offer one command; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int k = 0;
    while (!cmd_ready && k < 20) begin
      tick();
      k++;
    end
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b01;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
  endtask

  // Scoreboard: every response pulse must match a queued one.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("sb_err", 64'(rsp_error), 64'(e.err));
        chk("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pa;
    // Reset values.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_pen", 64'(PENABLE), 64'd0);
    chk("rst_pwr", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rv", 64'(rsp_valid), 64'd0);
    chk("rst_re", 64'(rsp_error), 64'd0);
    chk("rst_rd", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 64'(cmd_ready), 64'd1);

    // Write DATA_IN.
    send(OP_WRITE, AW'(REG_DATA_IN), 32'hA5A5A5A5);
    push(1'b0);
    chk("wr_setup_psel", 64'(PSEL), 64'd1);
    chk("wr_setup_pen", 64'(PENABLE), 64'd0);
    chk("wr_setup_pwr", 64'(PWRITE), 64'd1);
    chk("wr_paddr", 64'(PADDR), 64'h4);
    chk("wr_pwdata", 64'(PWDATA), 64'hA5A5A5A5);
    chk("wr_setup_rdy", 64'(cmd_ready), 64'd0);
    tick();
    chk("wr_acc_psel", 64'(PSEL), 64'd1);
    chk("wr_acc_pen", 64'(PENABLE), 64'd1);
    chk("wr_acc_paddr", 64'(PADDR), 64'h4);
    chk("wr_acc_pwdata", 64'(PWDATA), 64'hA5A5A5A5);
    tick();
    chk("wr_rv", 64'(rsp_valid), 64'd1);
    chk("wr_re", 64'(rsp_error), 64'd0);
    chk("wr_done_psel", 64'(PSEL), 64'd0);
    chk("wr_done_pwr", 64'(PWRITE), 64'd0);
    chk("wr_hold_paddr", 64'(PADDR), 64'h4);

    // Read NOISE with PRDATA = 3.
    PRDATA = 32'h3;
    send(OP_READ, AW'(REG_NOISE), 32'h0);
    m_rdata = 32'h3;
    push(1'b0);
    chk("rd_setup_pwr", 64'(PWRITE), 64'd0);
    chk("rd_setup_psel", 64'(PSEL), 64'd1);
    chk("rd_paddr", 64'(PADDR), 64'hC);
    tick();
    chk("rd_acc_pen", 64'(PENABLE), 64'd1);
    tick();
    PRDATA = 32'hDEAD0000;
    chk("rd_rv", 64'(rsp_valid), 64'd1);
    chk("rd_rdata", 64'(rsp_rdata), 64'h3);

    // Back-to-back: accept in the rsp_valid cycle.
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] pd;
      pd = $urandom;
      if (i[0]) begin
        PRDATA = pd;
        send(OP_READ, AW'(i * 4), 32'h0);
        m_rdata = pd;
      end else begin
        send(OP_WRITE, AW'(i * 4), pd);
      end
      push(1'b0);
      tick();
      tick();
      chk("b2b_rv", 64'(rsp_valid), 64'd1);
      chk("b2b_rdy", 64'(cmd_ready), 64'd1);
    end

    // Write CTRL then wait_done, done on 3rd wait cycle.
    send(OP_WRITE, AW'(REG_CTRL), 32'h1);
    push(1'b0);
    tick();
    tick();
    send(OP_WAIT, '0, '0);
    push(1'b0);
    chk("wd_psel", 64'(PSEL), 64'd0);
    tick();
    tick();
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    chk("wd_rv", 64'(rsp_valid), 64'd1);
    chk("wd_re", 64'(rsp_error), 64'd0);
    tick();
    chk("wd_rv_pulse", 64'(rsp_valid), 64'd0);

    // Timeout: done never arrives.
    send(OP_WAIT, '0, '0);
    push(1'b1);
    for (int i = 1; i < TO; i++) begin
      tick();
      if (rsp_valid) begin
        chk("to_early", 64'(i), 64'(TO));
      end
    end
    tick();
    chk("to_rv", 64'(rsp_valid), 64'd1);
    chk("to_re", 64'(rsp_error), 64'd1);

    // Done coinciding with the last wait cycle wins.
    send(OP_WAIT, '0, '0);
    push(1'b0);
    for (int i = 1; i < TO; i++) tick();
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    chk("to_edge_rv", 64'(rsp_valid), 64'd1);
    chk("to_edge_re", 64'(rsp_error), 64'd0);

    // Reset during ACCESS: no response.
    tick();
    send(OP_READ, AW'(REG_CODEWORD_WIDTH), 32'h0);
    tick();
    chk("rst_mid_pen", 64'(PENABLE), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rdata = '0;
    chk("rst_mid_psel", 64'(PSEL), 64'd0);
    chk("rst_mid_pen0", 64'(PENABLE), 64'd0);
    chk("rst_mid_rv", 64'(rsp_valid), 64'd0);
    tick();
    chk("rst_mid_rv2", 64'(rsp_valid), 64'd0);
    chk("rst_mid_rd", 64'(rsp_rdata), 64'd0);

    // Illegal op: error response, no APB activity.
    pa = PADDR;
    send(OP_ILLEGAL, 20'h12345, 32'h55);
    push(1'b1);
    chk("ill_psel0", 64'(PSEL), 64'd0);
    tick();
    chk("ill_psel1", 64'(PSEL), 64'd0);
    chk("ill_rv", 64'(rsp_valid), 64'd1);
    chk("ill_re", 64'(rsp_error), 64'd1);
    chk("ill_paddr", 64'(PADDR), 64'(pa));

    tick();
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-002 SHALL have parameter AMBA_WORD, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles spent waiting for operation_done (legal range >=2).
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 write, 01 read, 10 wait_done, 11 illegal.
- cmd_addr  in  AMBA_ADDR_WIDTH  target register address.
- cmd_wdata  in  AMBA_WORD  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  AMBA_WORD  read data, valid with rsp_valid.
- rsp_error  out  1  timeout or illegal op, valid with rsp_valid.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PRDATA  in  AMBA_WORD  APB read data from the ECC block.
- operation_done  in  1  ECC block completion flag.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, WAIT_DONE, ERR.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; all outputs SHALL be registered.
REQ-007 SHALL latch cmd_op, cmd_addr and cmd_wdata on acceptance; later input changes SHALL be ignored until the next acceptance.
REQ-008 On acceptance at edge N with op 00/01, the FSM SHALL be in SETUP after N (PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE stable) and in ACCESS after N+1 (PSEL=1, PENABLE=1).
REQ-009 SHALL have no wait states: ACCESS SHALL last exactly one cycle, then return to IDLE.
REQ-010 For a read, SHALL capture PRDATA at the edge leaving ACCESS and present it on rsp_rdata with rsp_valid=1 and rsp_error=0 in the following cycle.
REQ-011 For a write, SHALL pulse rsp_valid=1 (rsp_error=0) in the cycle after ACCESS; rsp_rdata SHALL hold its previous value.
REQ-012 PSEL, PENABLE and PWRITE SHALL be 0 in every state except SETUP/ACCESS; PADDR/PWDATA SHALL hold their last values.
REQ-013 For op 10, SHALL enter WAIT_DONE with a cycle counter cleared to 0, and SHALL sample operation_done from the first WAIT_DONE cycle onward.
REQ-014 In WAIT_DONE, operation_done=1 SHALL cause return to IDLE with rsp_valid=1, rsp_error=0 in the next cycle.
REQ-015 If the counter reaches TIMEOUT_CYCLES-1 with operation_done still 0, SHALL return to IDLE with rsp_valid=1, rsp_error=1; done and timeout in the same cycle SHALL report success.
REQ-016 The counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide and SHALL never wrap.
REQ-017 For op 11, SHALL go to ERR for one cycle, then IDLE with rsp_valid=1, rsp_error=1; no APB activity.
REQ-018 A new command SHALL be acceptable in the same cycle rsp_valid is high (back-to-back throughput: one APB transfer per 3 cycles).

Reset
REQ-019 On rst=1 at any edge, including mid-transfer, SHALL enter IDLE with PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, counter=0; cmd_ready=1 after reset release.
REQ-020 A command interrupted by reset SHALL produce no rsp_valid.

Structure
REQ-021 Shared package apb_master_pkg SHALL hold the state enum, cmd_op encodings and ECC register offsets (CTRL=0x00, DATA_IN=0x04, CODEWORD_WIDTH=0x08, NOISE=0x0C).
REQ-022 The block SHALL be a single module with no sub-modules; it SHALL connect to the ECC bench through the shared interface as the APB driver side.

Verification
REQ-023 Write addr 0x04, data 0xA5A5A5A5 -> SETUP/ACCESS on cycles N+1/N+2 with PWRITE=1; rsp_valid at N+3; rsp_error=0.
REQ-024 Read addr 0x0C with PRDATA=0x00000003 during ACCESS -> rsp_rdata=0x00000003 with rsp_valid one cycle later.
REQ-025 Write CTRL=0x00, then wait_done with operation_done asserted on the 3rd WAIT_DONE cycle -> rsp_valid, rsp_error=0, exactly 1 cycle later.
REQ-026 wait_done with operation_done held 0 and TIMEOUT_CYCLES=16 -> rsp_valid with rsp_error=1 in the cycle after the 16th WAIT_DONE cycle.
REQ-027 rst asserted during ACCESS -> PSEL=PENABLE=0 next cycle, no rsp_valid; an illegal op (11) -> rsp_error=1 with no PSEL pulse.
